// File: rtl/sel_scan8.sv
// sel_scan8: serializes an 8-bit word through an external selector8 mux.
// Walks the select bus across the held word and returns the mux output as a serial bit.
module sel_scan8 #(
    parameter bit DIR = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [0:7] din,
    input  logic       load_valid,
    output logic       load_ready,
    input  logic       bit_ready,
    input  logic       abort,
    output logic [2:0] s,
    output logic [0:7] a,
    input  logic       x,
    output logic       bit_out,
    output logic       bit_valid,
    output logic       last,
    output logic [7:0] wcnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [2:0] START = DIR ? 3'd7 : 3'd0;
    localparam logic [2:0] STOP  = DIR ? 3'd0 : 3'd7;

    state_t     state_q, state_d;
    logic [2:0] s_q, s_d;
    logic [0:7] a_q, a_d;
    logic [7:0] wcnt_q, wcnt_d;
    logic       last_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= 3'd0;
            a_q     <= 8'd0;
            wcnt_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            a_q     <= a_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign last_w = (s_q == STOP);

    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        a_d        = a_q;
        wcnt_d     = wcnt_q;
        load_ready = 1'b0;
        bit_valid  = 1'b0;
        last       = 1'b0;
        unique case (state_q)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    a_d     = din;
                    s_d     = START;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bit_valid = 1'b1;
                last      = last_w;
                // abort wins over a bit handshake, even on the final bit
                if (abort) begin
                    state_d = IDLE;
                end else if (bit_ready) begin
                    if (last_w) begin
                        state_d = IDLE;
                        wcnt_d  = wcnt_q + 8'd1;
                    end else begin
                        s_d = DIR ? s_q - 3'd1 : s_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign s       = s_q;
    assign a       = a_q;
    assign wcnt    = wcnt_q;
    assign bit_out = x;

endmodule

// File: tb/tb_sel_scan8.sv
// Bench for sel_scan8: both scan directions side by side, a word-level
// reference model checked every cycle, plus directed literal checks.
module tb_sel_scan8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [0:7] din = 8'd0;
    logic       load_valid = 1'b0;
    logic       bit_ready = 1'b0;
    logic       abort = 1'b0;

    logic       lr [2];
    logic       bv [2];
    logic       lst[2];
    logic       bo [2];
    logic       xx [2];
    logic [2:0] sw [2];
    logic [0:7] aw [2];
    logic [7:0] wc [2];

    int errors = 0;
    int checks = 0;
    bit armed = 1'b0;

    always #5 clk = ~clk;

    sel_scan8 #(.DIR(1'b0)) u0 (
        .clk(clk), .rst(rst), .din(din), .load_valid(load_valid),
        .load_ready(lr[0]), .bit_ready(bit_ready), .abort(abort),
        .s(sw[0]), .a(aw[0]), .x(xx[0]), .bit_out(bo[0]),
        .bit_valid(bv[0]), .last(lst[0]), .wcnt(wc[0])
    );

    sel_scan8 #(.DIR(1'b1)) u1 (
        .clk(clk), .rst(rst), .din(din), .load_valid(load_valid),
        .load_ready(lr[1]), .bit_ready(bit_ready), .abort(abort),
        .s(sw[1]), .a(aw[1]), .x(xx[1]), .bit_out(bo[1]),
        .bit_valid(bv[1]), .last(lst[1]), .wcnt(wc[1])
    );

    // behavioural selector8: x = a[s]
    assign xx[0] = aw[0][sw[0]];
    assign xx[1] = aw[1][sw[1]];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: word position k counts bits already handed off
    bit         busy [2];
    int         k    [2];
    logic [0:7] mword[2];
    logic [7:0] mw   [2];
    logic [2:0] ms   [2];

    function automatic logic [2:0] pos(input int d, input int kk);
        return (d == 1) ? 3'(7 - kk) : 3'(kk);
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                busy[d] = 1'b0; k[d] = 0; mword[d] = 8'd0; mw[d] = 8'd0; ms[d] = 3'd0;
            end else if (!busy[d]) begin
                if (load_valid) begin
                    mword[d] = din; k[d] = 0; busy[d] = 1'b1; ms[d] = pos(d, 0);
                end
            end else if (abort) begin
                busy[d] = 1'b0;
            end else if (bit_ready) begin
                if (k[d] == 7) begin
                    busy[d] = 1'b0; mw[d] = mw[d] + 8'd1;
                end else begin
                    k[d] = k[d] + 1; ms[d] = pos(d, k[d]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("load_ready%0d", d), 32'(lr[d]), 32'(!busy[d]));
                chk($sformatf("bit_valid%0d", d), 32'(bv[d]), 32'(busy[d]));
                chk($sformatf("last%0d", d), 32'(lst[d]), 32'(busy[d] && k[d] == 7));
                chk($sformatf("s%0d", d), 32'(sw[d]), 32'(ms[d]));
                chk($sformatf("a%0d", d), 32'(aw[d]), 32'(mword[d]));
                chk($sformatf("wcnt%0d", d), 32'(wc[d]), 32'(mw[d]));
                if (busy[d])
                    chk($sformatf("bit_out%0d", d), 32'(bo[d]), 32'(mword[d][pos(d, k[d])]));
            end
        end
    end

    logic [7:0] seq0, seq1;
    int sc0 = 0;
    int done0 = 0;

    task automatic step();
        @(negedge clk);
        if (bv[0] && bit_ready && !abort && !rst) seq0 = {seq0[6:0], bo[0]};
        if (bv[1] && bit_ready && !abort && !rst) seq1 = {seq1[6:0], bo[1]};
        if (bv[0] && !rst) sc0++;
        if (lst[0] && bv[0] && bit_ready && !abort && !rst) done0++;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] w);
        din = w; load_valid = 1'b1; bit_ready = 1'b1;
        step();
        load_valid = 1'b0;
        for (int i = 0; i < 8; i++) step();
    endtask

    initial begin
        seq0 = '0; seq1 = '0;
        step();
        step();
        armed = 1'b1;
        rst = 1'b0;
        chk("rst_load_ready", 32'(lr[0]), 32'd1);
        chk("rst_s", 32'(sw[0]), 32'd0);

        send(8'b10000000);
        chk("dir0_seq_80", 32'(seq0), 32'h80);
        chk("dir1_seq_80", 32'(seq1), 32'h01);
        chk("wcnt_after_1", 32'(wc[0]), 32'd1);
        chk("s_end_dir0", 32'(sw[0]), 32'd7);

        send(8'b00000001);
        chk("dir1_seq_01", 32'(seq1), 32'h80);
        chk("dir0_seq_01", 32'(seq0), 32'h01);
        chk("s_end_dir1", 32'(sw[1]), 32'd0);

        // stall on shift cycles 2-4
        sc0 = 0;
        din = 8'b01000000; load_valid = 1'b1; bit_ready = 1'b1;
        step();
        load_valid = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            bit_ready = !(c >= 2 && c <= 4);
            step();
        end
        bit_ready = 1'b1;
        chk("stall_cycles", 32'(sc0), 32'd11);
        chk("stall_seq0", 32'(seq0), 32'h40);
        chk("stall_seq1", 32'(seq1), 32'h02);
        chk("stall_wcnt", 32'(wc[0]), 32'd3);

        // abort on the 4th bit
        din = 8'hFF; load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        for (int c = 0; c < 3; c++) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_idle", 32'(lr[0]), 32'd1);
        chk("abort_wcnt", 32'(wc[0]), 32'd3);
        seq0 = '0;
        send(8'b00001111);
        chk("after_abort_seq", 32'(seq0), 32'h0F);
        chk("after_abort_wcnt", 32'(wc[0]), 32'd4);

        // reset mid-word
        din = 8'hA5; load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        for (int c = 0; c < 5; c++) step();
        chk("mid_s5", 32'(sw[0]), 32'd5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_s", 32'(sw[0]), 32'd0);
        chk("midrst_a", 32'(aw[0]), 32'd0);
        chk("midrst_wcnt", 32'(wc[0]), 32'd0);
        chk("midrst_lr", 32'(lr[0]), 32'd1);
        chk("midrst_bv", 32'(bv[0]), 32'd0);

        // 256 back-to-back words
        done0 = 0;
        load_valid = 1'b1; bit_ready = 1'b1;
        for (int c = 0; c < 256 * 9; c++) begin
            din = 8'($urandom);
            step();
        end
        load_valid = 1'b0;
        chk("b2b_words", 32'(done0), 32'd256);
        chk("b2b_wrap0", 32'(wc[0]), 32'd0);
        chk("b2b_wrap1", 32'(wc[1]), 32'd0);
        chk("b2b_idle", 32'(lr[0]), 32'd1);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            din        = 8'($urandom);
            load_valid = ($urandom_range(0, 1) == 1);
            bit_ready  = ($urandom_range(0, 3) != 0);
            abort      = ($urandom_range(0, 15) == 0);
            rst        = ($urandom_range(0, 127) == 0);
            step();
        end
        rst = 1'b0; abort = 1'b0; load_valid = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
